// File: rtl/ret_addr_stack.sv
// ret_addr_stack
// Circular return-address stack. A call pushes its return address and a ret
// pops the newest entry. When the stack is full, a push overwrites the oldest
// entry. Overflow and underflow are recorded in sticky flags; the pipeline is
// never halted.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       call,
  input  logic [WIDTH-1:0]           PC_ret_addr,
  input  logic                       ret,
  input  logic                       stall,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           PC_stack_pointer,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(DEPTH);
  localparam logic [WIDTH-1:0] ADDR_ZERO = WIDTH'(0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    tp_q, tp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             do_call_s;
  logic             do_ret_s;
  logic [PW-1:0]    top_idx_s;
  logic             wr_en_s;
  logic [PW-1:0]    wr_idx_s;

  // A stall masks both control pulses.
  assign do_call_s = call & ~stall;
  assign do_ret_s  = ret  & ~stall;

  // The newest entry sits one slot below the next-free pointer. The index
  // wraps modulo DEPTH.
  assign top_idx_s = tp_q - PTR_ONE;

  // Next-state logic for the pointer, the count, the sticky flags and the
  // single write port.
  always_comb begin
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    // err_clr is applied first so that a flag-setting event below wins.
    overflow_d  = overflow_q  & ~err_clr;
    underflow_d = underflow_q & ~err_clr;
    wr_en_s     = 1'b0;
    wr_idx_s    = tp_q;

    case ({do_call_s, do_ret_s})
      2'b10: begin
        // Push. When full, the write lands on the oldest slot.
        wr_en_s  = 1'b1;
        wr_idx_s = tp_q;
        tp_d     = tp_q + PTR_ONE;
        if (cnt_q == CNT_FULL) begin
          overflow_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      2'b01: begin
        // Pop. Popped data is left in place; only the pointer moves.
        if (cnt_q != CNT_ZERO) begin
          tp_d  = tp_q - PTR_ONE;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
      2'b11: begin
        // Replace the top entry. On an empty stack this acts as a plain push.
        wr_en_s = 1'b1;
        if (cnt_q == CNT_ZERO) begin
          wr_idx_s = tp_q;
          tp_d     = tp_q + PTR_ONE;
          cnt_d    = CNT_ONE;
        end else begin
          wr_idx_s = top_idx_s;
        end
      end
      default: begin
        tp_d  = tp_q;
        cnt_d = cnt_q;
      end
    endcase
  end

  // Next-state storage array: copy the current contents, then apply the
  // single write.
  always_comb begin
    mem_d = mem_q;
    if (wr_en_s) begin
      mem_d[wr_idx_s] = PC_ret_addr;
    end else begin
      mem_d = mem_q;
    end
  end

  // Control state. Reset is asynchronous and discards all entries at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_q        <= {PW{1'b0}};
      cnt_q       <= CNT_ZERO;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It has no reset because only cnt decides which entries
  // are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Outputs are decoded from registered state only.
  assign PC_stack_pointer = (cnt_q != CNT_ZERO) ? mem_q[top_idx_s] : ADDR_ZERO;
  assign empty            = (cnt_q == CNT_ZERO);
  assign full             = (cnt_q == CNT_FULL);
  assign count            = cnt_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Testbench for ret_addr_stack. It runs directed steps from the test plan,
// then random traffic. Every step is compared against a queue-based LIFO
// model.
module tb_ret_addr_stack;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             call;
  logic [WIDTH-1:0] pc_in;
  logic             ret;
  logic             stall;
  logic             err_clr;
  logic [WIDTH-1:0] top;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the queue's back is the top of the stack, and its
  // front is the oldest entry.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovf;
  bit               m_unf;

  ret_addr_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .call             (call),
    .PC_ret_addr      (pc_in),
    .ret              (ret),
    .stall            (stall),
    .err_clr          (err_clr),
    .PC_stack_pointer (top),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string where);
    logic [WIDTH-1:0] exp_top;
    exp_top = (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000;
    check({where, ".top"},       32'(top),       32'(exp_top));
    check({where, ".count"},     32'(count),     32'(mq.size()));
    check({where, ".empty"},     32'(empty),     32'(mq.size() == 0));
    check({where, ".full"},      32'(full),      32'(mq.size() == DEPTH));
    check({where, ".overflow"},  32'(overflow),  32'(m_ovf));
    check({where, ".underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_update(input bit c, input bit r, input bit s, input bit e,
                              input logic [WIDTH-1:0] a);
    if (e) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (!s) begin
      if (c && !r) begin
        if (mq.size() == DEPTH) begin
          void'(mq.pop_front());
          m_ovf = 1'b1;
        end
        mq.push_back(a);
      end else if (!c && r) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else m_unf = 1'b1;
      end else if (c && r) begin
        if (mq.size() == 0) mq.push_back(a);
        else mq[mq.size()-1] = a;
      end
    end
  endtask

  // Drive one cycle of inputs, clock the DUT, then check the outputs on the
  // falling edge that follows.
  task automatic step(input string tag, input bit c, input bit r, input bit s, input bit e,
                      input logic [WIDTH-1:0] a);
    call = c; ret = r; stall = s; err_clr = e; pc_in = a;
    @(posedge clk);
    model_update(c, r, s, e, a);
    @(negedge clk);
    call = 1'b0; ret = 1'b0; stall = 1'b0; err_clr = 1'b0;
    pc_in = $urandom_range(0, 65535);
    check_all(tag);
  endtask

  task automatic push(input string tag, input logic [WIDTH-1:0] a);
    step(tag, 1'b1, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic pop(input string tag);
    step(tag, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
  endtask

  // Assert reset between clock edges and check that it takes effect at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_all({tag, ".after"});
  endtask

  initial begin
    rst_n = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0; err_clr = 1'b0; pc_in = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all("idle");

    // LIFO order
    push("lifo.push1", 16'h0011);
    push("lifo.push2", 16'h0022);
    push("lifo.push3", 16'h0033);
    check("lifo.top3", 32'(top), 32'h0033);
    pop("lifo.pop1");
    check("lifo.pop1_top", 32'(top), 32'h0022);
    pop("lifo.pop2");
    check("lifo.pop2_top", 32'(top), 32'h0011);
    pop("lifo.pop3");
    check("lifo.pop3_empty", 32'(empty), 32'h1);

    // Overflow wrap: the fifth push overwrites the oldest entry.
    for (int i = 1; i <= 5; i++) push("ovf.push", 16'(i));
    check("ovf.flag", 32'(overflow), 32'h1);
    check("ovf.full", 32'(full), 32'h1);
    for (int i = 5; i >= 2; i--) begin
      pop("ovf.pop");
      if (i > 2) check("ovf.pop_top", 32'(top), 32'(i - 1));
    end
    check("ovf.no_unf", 32'(underflow), 32'h0);

    // Underflow and error clear
    pop("unf.pop_empty");
    check("unf.flag", 32'(underflow), 32'h1);
    step("unf.clr", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check("unf.cleared", 32'(underflow), 32'h0);
    step("unf.clr_and_pop", 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000);
    check("unf.set_wins", 32'(underflow), 32'h1);
    step("unf.clr2", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

    // Simultaneous call and ret
    push("rep.push1", 16'h0011);
    push("rep.push2", 16'h0022);
    step("rep.replace", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0099);
    check("rep.top", 32'(top), 32'h0099);
    check("rep.count", 32'(count), 32'h2);
    pop("rep.pop1");
    pop("rep.pop2");
    step("rep.on_empty", 1'b1, 1'b1, 1'b0, 1'b0, 16'h0077);
    check("rep.empty_count", 32'(count), 32'h1);
    check("rep.empty_unf", 32'(underflow), 32'h0);

    // Stall
    push("stall.pre", 16'h0123);
    step("stall.call", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0ABC);
    step("stall.ret",  1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
    step("stall.both", 1'b1, 1'b1, 1'b1, 1'b0, 16'h0ABC);
    check("stall.top_held", 32'(top), 32'h0123);
    push("stall.release", 16'h0ABC);
    check("stall.push_top", 32'(top), 32'h0ABC);

    // Asynchronous reset mid-operation
    check("arst.pre_nonempty", 32'(empty), 32'h0);
    async_reset("arst1");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 15) == 0),
           16'($urandom_range(0, 65535)));
      if (i == 200) async_reset("arst_rand");
    end

    async_reset("arst_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
